// File: rtl/s_serial_rcs4_pkg.sv
// rtl/s_serial_rcs4_pkg.sv - shared constants and state type for the serial subtractor
package s_serial_rcs4_pkg;
    localparam int RCS_N     = 4;
    localparam int RCS_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rcs_state_e;
endpackage

// File: rtl/s_serial_rcs4_fs.sv
// rtl/s_serial_rcs4_fs.sv - one-bit full subtractor stage
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/s_serial_rcs4.sv
// rtl/s_serial_rcs4.sv - bit-serial 4-bit subtractor, one bit per cycle, LSB first
module s_serial_rcs4
    import s_serial_rcs4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RCS_N-1:0] a,
    input  logic [RCS_N-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [RCS_N:0]   out
);
    localparam logic [RCS_CNT_W-1:0] CNT_LAST = RCS_CNT_W'(RCS_N - 1);

    rcs_state_e           state_q;
    logic [RCS_N-1:0]     a_sh_q;
    logic [RCS_N-1:0]     b_sh_q;
    logic [RCS_N-1:0]     res_q;
    logic                 borrow_q;
    logic [RCS_CNT_W-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [RCS_N:0]       out_q;

    logic fs_d;
    logic fs_bout;

    fs u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        out_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    res_q    <= {fs_d, res_q[RCS_N-1:1]};
                    a_sh_q   <= {1'b0, a_sh_q[RCS_N-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[RCS_N-1:1]};
                    borrow_q <= fs_bout;
                    cnt_q    <= cnt_q + 1'b1;
                    // Last bit: publish straight from the stage so out is valid in DONE.
                    if (cnt_q == CNT_LAST) begin
                        out_q   <= {fs_bout, fs_d, res_q[RCS_N-1:1]};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
endmodule

// File: tb/tb_s_serial_rcs4.sv
// tb/tb_s_serial_rcs4.sv - directed self-checking bench for s_serial_rcs4
module tb_s_serial_rcs4;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [4:0] out;

    int n_cmp;
    int n_bad;
    int cyc;

    s_serial_rcs4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start for one cycle and follow the operation to its done pulse.
    task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                         input logic [4:0] expv, input string tag, output int done_cyc);
        int lat;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            if (lat <= 4) chk({tag, " busy"}, 32'(busy), 32'd1);
            tick();
            lat++;
        end
        done_cyc = cyc;
        chk({tag, " latency"}, 32'(lat), 32'd5);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " out"}, 32'(out), 32'(expv));
        tick();
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " out hold"}, 32'(out), 32'(expv));
    endtask

    initial begin
        int dc;
        int prev_dc;
        int ndone;
        logic [4:0] seen;
        logic [4:0] e;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        rst = 1'b1;
        start = 1'b1;
        a = 4'd0;
        b = 4'd0;
        tick();
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset out", 32'(out), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        do_op(4'd9,  4'd3,  5'b00110, "9-3",   dc);
        do_op(4'd3,  4'd9,  5'b11010, "3-9",   dc);
        do_op(4'd0,  4'd15, 5'b10001, "0-15",  dc);
        do_op(4'd15, 4'd15, 5'b00000, "15-15", dc);
        do_op(4'd15, 4'd0,  5'b01111, "15-0",  dc);

        // Operands and start disturbed while running.
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'd1;
        b = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        seen = 5'h1f;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                ndone++;
                seen = out;
            end
            tick();
        end
        chk("disturb done count", 32'(ndone), 32'd1);
        chk("disturb out", 32'(seen), 32'b00110);

        // Reset in cycle T+3 aborts the operation.
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort out", 32'(out), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort no done", 32'(ndone), 32'd0);
        do_op(4'd9, 4'd3, 5'b00110, "after abort", dc);

        // Exhaustive back-to-back sweep.
        prev_dc = -1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                e = 5'(ai - bi);
                do_op(4'(ai), 4'(bi), e, $sformatf("sweep %0d-%0d", ai, bi), dc);
                if (prev_dc >= 0) chk("sweep spacing", 32'(dc - prev_dc), 32'd6);
                prev_dc = dc;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/s_serial_rcs4.md
S_SERIAL_RCS4 -- requirements
Module: s_serial_rcs4

Interface
REQ-001 Parameter: none; operand width fixed at N=4 through the package constant RCS_N.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  4  minuend, unsigned; captured when start is accepted.
REQ-006 b  input  4  subtrahend, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while the state is RUN.
REQ-008 done  output  1  one-cycle pulse; out is valid in this cycle.
REQ-009 out  output  5  result; out[3:0] is the difference, out[4] is the final borrow.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 IDLE with start=1: register a and b into operand shift registers, clear the borrow flop and the bit counter, clear out, and go to RUN.
REQ-012 IDLE with start=0: remain in IDLE; out holds its last value.
REQ-013 RUN: each cycle, one full-subtractor stage takes the LSB of a_sh, the LSB of b_sh and the borrow flop.
  - Stage outputs: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - Shift d into the result register from the MSB side.
  - Shift both operand registers right.
  - Load bout into the borrow flop.
  - Increment the counter.
REQ-014 RUN SHALL last exactly RCS_N=4 cycles, processing bit 0 through bit 3; after the cycle with counter=3, go to DONE.
REQ-015 DONE: assert done=1 for exactly one cycle, then return to IDLE.
  - out[3:0] = the 4 result bits; out[4] = the final borrow.
  - out = (a - b) mod 32, the 5-bit two's-complement difference.
REQ-016 out SHALL hold its value from DONE until the next accepted start.
REQ-017 Latency: start is sampled high in cycle T; busy=1 in cycles T+1..T+4; done=1 in cycle T+5.
REQ-018 start SHALL be ignored in RUN and DONE; captured operands are not disturbed.
REQ-019 Back-to-back: a start in the IDLE cycle directly after DONE SHALL be accepted, giving a minimum issue interval of 6 cycles.
REQ-020 Changes on a or b after acceptance SHALL have no effect on the running operation.
REQ-021 busy and done SHALL never be high in the same cycle.

Reset
REQ-022 rst=1 at a clock edge SHALL force the following, overriding start:
  - state IDLE, busy=0, done=0, out=5'b00000;
  - borrow flop, counter and shift registers cleared.
REQ-023 Reset mid-RUN or in DONE SHALL abort the operation; no done pulse is produced for the aborted operation.

Structure
REQ-024 A shared package SHALL hold RCS_N=4, the counter width (2 bits) and the state enum typedef (IDLE, RUN, DONE).
REQ-025 The full-subtractor SHALL be a separate combinational sub-module fs with ports a, b, bin, d and bout, instantiated once.
REQ-026 The datapath SHALL consist of two operand shift registers, a result shift register, one borrow flop and the counter; there SHALL be no combinational 4-bit subtractor.

Verification
REQ-027 Scenario: a=9, b=3, start pulse -> busy for 4 cycles; done in cycle T+5 with out=5'b00110.
REQ-028 Scenario: a=3, b=9 -> out=5'b11010 (borrow=1, -6); a=0, b=15 -> out=5'b10001.
REQ-029 Scenario: a=15, b=15 -> out=5'b00000; a=15, b=0 -> out=5'b01111.
REQ-030 Scenario: start with a=9, b=3 and operands changed to a=1, b=2 in cycle T+2, plus start re-pulsed in cycle T+2 -> result is still 5'b00110 and exactly one done pulse.
REQ-031 Scenario: start pulse, then rst in cycle T+3 -> no done pulse; out=0, busy=0 next cycle; a new start then yields the correct result.
REQ-032 Scenario: exhaustive sweep of all 256 (a, b) pairs using back-to-back starts -> every out equals (a-b) mod 32 and done spacing is 6 cycles.
